// File: rtl/bira_pkg.sv
// Shared widths, fault record and controller state encoding for the BIRA fault front-end.
package bira_pkg;

   localparam int unsigned ROW_W  = 10;
   localparam int unsigned COL_W  = 10;
   localparam int unsigned BNK_W  = 2;
   localparam int unsigned FLAG_W = 8;

   typedef struct packed {
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic [BNK_W-1:0]  bank;
      logic [FLAG_W-1:0] flag;
   } fault_t;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StCollect,
      StDrain,
      StTerm,
      StSink,
      StDone
   } state_e;

endpackage

// File: rtl/bira_fault_fifo.sv
// Synchronous fault FIFO; a push while full is accepted when a pop happens in the same cycle.
module bira_fault_fifo
   import bira_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   push,
   input  logic   pop,
   input  fault_t wdata,
   output fault_t rdata,
   output logic   full,
   output logic   empty
);

   localparam int unsigned AW = $clog2(Depth);

   fault_t         mem_q [Depth];
   logic [AW:0]    wptr_q, wptr_d;
   logic [AW:0]    rptr_q, rptr_d;
   logic           do_push, do_pop;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/bira_fault_sched.sv
// BIRA fault CAM front-end: round-robin arbiter, fault FIFO, one-outstanding CAM issue, overflow.
// Build option FAULT_DEDUP_EN drops a popped fault equal to the last issued one.
module bira_fault_sched
   import bira_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned PCAM       = 8,
   parameter int unsigned NPCAM      = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      bist_done,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ROW_W-1:0]  req_row,
   input  logic [NUM_REQ*COL_W-1:0]  req_col,
   input  logic [NUM_REQ*FLAG_W-1:0] req_col_flag,
   output logic                      cam_valid,
   output logic [ROW_W-1:0]          cam_row_addr,
   output logic [COL_W-1:0]          cam_col_addr,
   output logic [BNK_W-1:0]          cam_bank_addr,
   output logic [FLAG_W-1:0]         cam_col_flag,
   input  logic                      cam_rsp_valid,
   input  logic                      cam_rsp_new_pivot,
   output logic                      cam_early_term,
   output logic                      busy,
   output logic                      done,
   output logic                      unrepairable,
   output logic [3:0]                pivot_cnt,
   output logic [4:0]                nonpivot_cnt,
   output logic [15:0]               fault_cnt
);

   localparam int unsigned RrW       = $clog2(NUM_REQ);
   localparam logic [3:0]  PcamFull  = 4'(PCAM);
   localparam logic [4:0]  NpcamFull = 5'(NPCAM);

   state_e           state_q, state_d;
   logic [RrW-1:0]   rr_q, rr_d;
   logic [3:0]       pivot_q, pivot_d;
   logic [4:0]       nonpivot_q, nonpivot_d;
   logic [15:0]      fault_q, fault_d;
   logic             unrep_q, unrep_d;
   logic             out_q, out_d;

   logic [RrW-1:0]   cand, gnt_idx;
   logic             gnt_found;
   fault_t           push_data, fifo_head;
   logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic             active, issue, dup, overflow;

   // Rotating priority search starting at rr_q.
   always_comb begin
      cand      = rr_q;
      gnt_found = 1'b0;
      gnt_idx   = rr_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
         cand = (cand == RrW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      end
      push_data = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (RrW'(j) == gnt_idx) begin
            push_data.row  = req_row[j*ROW_W +: ROW_W];
            push_data.col  = req_col[j*COL_W +: COL_W];
            push_data.flag = req_col_flag[j*FLAG_W +: FLAG_W];
            push_data.bank = BNK_W'(j);
         end
      end
   end

   assign active    = (state_q == StCollect) || (state_q == StDrain);
   assign fifo_push = (state_q == StCollect) && !fifo_full && gnt_found;
   assign fifo_pop  = active && !fifo_empty && !out_q;
   assign issue     = fifo_pop && !dup;

`ifdef FAULT_DEDUP_EN
   fault_t last_q, last_d;
   logic   last_vld_q, last_vld_d;

   always_comb begin
      last_d     = last_q;
      last_vld_d = last_vld_q;
      if (state_q == StClear) begin
         last_vld_d = 1'b0;
      end else if (issue) begin
         last_d     = fifo_head;
         last_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else begin
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
      end
   end

   assign dup = last_vld_q && (fifo_head == last_q);
`else
   assign dup = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      rr_d           = rr_q;
      pivot_d        = pivot_q;
      nonpivot_d     = nonpivot_q;
      fault_d        = fault_q;
      unrep_d        = unrep_q;
      out_d          = out_q;
      req_ready      = '0;
      cam_early_term = 1'b0;
      fifo_flush     = 1'b0;
      overflow       = 1'b0;

      if (cam_rsp_valid) out_d = 1'b0;
      if (issue)         out_d = 1'b1;

      if (cam_rsp_valid && active) begin
         if (cam_rsp_new_pivot) begin
            if (pivot_q == PcamFull) overflow = 1'b1;
            else                     pivot_d  = pivot_q + 4'd1;
         end else begin
            if (nonpivot_q == NpcamFull) overflow   = 1'b1;
            else                         nonpivot_d = nonpivot_q + 5'd1;
         end
      end

      if (fifo_push) begin
         req_ready = NUM_REQ'(1) << gnt_idx;
         rr_d      = (gnt_idx == RrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         if (fault_q != 16'hFFFF) fault_d = fault_q + 16'd1;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d    = StClear;
               pivot_d    = '0;
               nonpivot_d = '0;
               fault_d    = '0;
               unrep_d    = 1'b0;
            end
         end
         StClear: begin
            cam_early_term = 1'b1;
            fifo_flush     = 1'b1;
            out_d          = 1'b0;
            state_d        = StCollect;
         end
         StCollect: begin
            if (overflow)       state_d = StTerm;
            else if (bist_done) state_d = StDrain;
         end
         StDrain: begin
            if (overflow)                    state_d = StTerm;
            else if (fifo_empty && !out_q)   state_d = StDone;
         end
         StTerm: begin
            cam_early_term = 1'b1;
            unrep_d        = 1'b1;
            fifo_flush     = 1'b1;
            out_d          = 1'b0;
            state_d        = StSink;
         end
         StSink: begin
            // Accept and discard everything so the BIST engines can finish.
            req_ready = '1;
            if (bist_done) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         rr_q       <= '0;
         pivot_q    <= '0;
         nonpivot_q <= '0;
         fault_q    <= '0;
         unrep_q    <= 1'b0;
         out_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         pivot_q    <= pivot_d;
         nonpivot_q <= nonpivot_d;
         fault_q    <= fault_d;
         unrep_q    <= unrep_d;
         out_q      <= out_d;
      end
   end

   bira_fault_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (push_data),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cam_valid     = issue;
   assign cam_row_addr  = issue ? fifo_head.row  : '0;
   assign cam_col_addr  = issue ? fifo_head.col  : '0;
   assign cam_bank_addr = issue ? fifo_head.bank : '0;
   assign cam_col_flag  = issue ? fifo_head.flag : '0;
   assign busy          = (state_q != StIdle) && (state_q != StDone);
   assign done          = (state_q == StDone);
   assign unrepairable  = unrep_q;
   assign pivot_cnt     = pivot_q;
   assign nonpivot_cnt  = nonpivot_q;
   assign fault_cnt     = fault_q;

endmodule

// File: tb/tb_bira_fault_sched.sv
// Directed, table-driven bench for bira_fault_sched with an auto-responding CAM model.
module tb_bira_fault_sched;

   logic        clk, rst, start, bist_done;
   logic [3:0]  req_valid, req_ready;
   logic [39:0] req_row, req_col;
   logic [31:0] req_col_flag;
   logic        cam_valid;
   logic [9:0]  cam_row_addr, cam_col_addr;
   logic [1:0]  cam_bank_addr;
   logic [7:0]  cam_col_flag;
   logic        cam_rsp_valid, cam_rsp_new_pivot, cam_early_term;
   logic        busy, done, unrepairable;
   logic [3:0]  pivot_cnt;
   logic [4:0]  nonpivot_cnt;
   logic [15:0] fault_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_issued = 0;
   logic rsp_pivot = 1'b0;

`ifdef FAULT_DEDUP_EN
   localparam int DupIssues = 1;
`else
   localparam int DupIssues = 2;
`endif

   typedef struct {
      logic [3:0] valid;
      logic [3:0] exp_ready;
   } vec_t;
   vec_t tbl [14];

   bira_fault_sched dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .bist_done         (bist_done),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_row           (req_row),
      .req_col           (req_col),
      .req_col_flag      (req_col_flag),
      .cam_valid         (cam_valid),
      .cam_row_addr      (cam_row_addr),
      .cam_col_addr      (cam_col_addr),
      .cam_bank_addr     (cam_bank_addr),
      .cam_col_flag      (cam_col_flag),
      .cam_rsp_valid     (cam_rsp_valid),
      .cam_rsp_new_pivot (cam_rsp_new_pivot),
      .cam_early_term    (cam_early_term),
      .busy              (busy),
      .done              (done),
      .unrepairable      (unrepairable),
      .pivot_cnt         (pivot_cnt),
      .nonpivot_cnt      (nonpivot_cnt),
      .fault_cnt         (fault_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; the CAM model answers exactly one cycle after each issue.
   task automatic step();
      logic iss;
      iss = cam_valid;
      @(posedge clk);
      #1;
      cam_rsp_valid     = iss;
      cam_rsp_new_pivot = rsp_pivot;
      if (iss) n_issued++;
   endtask

   task automatic do_reset();
      rst = 1'b0; start = 1'b0; bist_done = 1'b0; req_valid = '0;
      cam_rsp_valid = 1'b0; cam_rsp_new_pivot = 1'b0; rsp_pivot = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_issued = 0;
   endtask

   task automatic set_bank(input int b, input logic [9:0] row, input logic [9:0] col,
                           input logic [7:0] flag);
      req_row[b*10 +: 10]     = row;
      req_col[b*10 +: 10]     = col;
      req_col_flag[b*8 +: 8]  = flag;
   endtask

   task automatic begin_session();
      start = 1'b1;
      #1;
      step();
      start = 1'b0;
      check("clear_early_term", {63'd0, cam_early_term}, 64'd1);
      check("clear_busy", {63'd0, busy}, 64'd1);
      step();
      n_issued = 0;
   endtask

   task automatic wait_done(input string name, input int limit);
      for (int i = 0; i < limit && !done; i++) step();
      check(name, {63'd0, done}, 64'd1);
   endtask

   initial begin
      rst = 1'b0;
      for (int b = 0; b < 4; b++) set_bank(b, 10'(b * 10 + 1), 10'(b + 2), 8'(1 << b));
      tbl[0]  = '{4'b1111, 4'b0001};
      tbl[1]  = '{4'b1111, 4'b0010};
      tbl[2]  = '{4'b1111, 4'b0100};
      tbl[3]  = '{4'b1111, 4'b1000};
      tbl[4]  = '{4'b1111, 4'b0001};
      tbl[5]  = '{4'b1111, 4'b0010};
      tbl[6]  = '{4'b1111, 4'b0100};
      tbl[7]  = '{4'b1111, 4'b0000};
      tbl[8]  = '{4'b0101, 4'b0001};
      tbl[9]  = '{4'b0101, 4'b0000};
      tbl[10] = '{4'b0101, 4'b0100};
      tbl[11] = '{4'b0000, 4'b0000};
      tbl[12] = '{4'b1000, 4'b1000};
      tbl[13] = '{4'b0010, 4'b0000};

      // Reset state and single-fault session.
      do_reset();
      check("reset_outputs", {req_ready, cam_valid, cam_row_addr, cam_col_addr, cam_bank_addr,
            cam_col_flag, cam_early_term, busy, done, unrepairable, pivot_cnt, nonpivot_cnt,
            fault_cnt}, 64'd0);
      begin_session();
      set_bank(1, 10'd5, 10'd3, 8'h01);
      rsp_pivot = 1'b1;
      req_valid = 4'b0010;
      #1 check("t1_grant", 64'(req_ready), 64'h2);
      step();
      req_valid = '0;
      #1;
      check("t1_cam_valid", {63'd0, cam_valid}, 64'd1);
      check("t1_cam_fields", {cam_row_addr, cam_col_addr, cam_bank_addr, cam_col_flag},
            {10'd5, 10'd3, 2'd1, 8'h01});
      step();
      step();
      check("t1_pivot_cnt", 64'(pivot_cnt), 64'd1);
      bist_done = 1'b1;
      wait_done("t1_done", 20);
      bist_done = 1'b0;
      check("t1_unrep_fault", {unrepairable, fault_cnt}, {1'b0, 16'd1});

      // Round-robin order and FIFO-full stall.
      do_reset();
      set_bank(1, 10'd11, 10'd3, 8'h02);
      begin_session();
      for (int i = 0; i < 14; i++) begin
         req_valid = tbl[i].valid;
         #1;
         check($sformatf("rr_vec%0d", i), 64'(req_ready), 64'(tbl[i].exp_ready));
         check($sformatf("rr_onehot%0d", i), 64'($countones(req_ready) <= 1), 64'd1);
         step();
      end
      req_valid = '0;
      bist_done = 1'b1;
      wait_done("t2_done", 60);
      bist_done = 1'b0;
      check("t2_counts", {fault_cnt, nonpivot_cnt, pivot_cnt, unrepairable},
            {16'd10, 5'd10, 4'd0, 1'b0});

      // Pivot overflow on the 9th new-pivot response.
      do_reset();
      begin_session();
      rsp_pivot = 1'b1;
      req_valid = 4'b0001;
      for (int i = 0; i < 100 && !cam_early_term; i++) step();
      check("t3_term_pulse", {63'd0, cam_early_term}, 64'd1);
      check("t3_issued", 64'(n_issued), 64'd9);
      check("t3_pivot_full", 64'(pivot_cnt), 64'd8);
      step();
      check("t3_unrep", {63'd0, unrepairable}, 64'd1);
      check("t3_sink_ready", 64'(req_ready), 64'hF);
      check("t3_term_single", {63'd0, cam_early_term}, 64'd0);
      check("t3_fault_cnt", 64'(fault_cnt), 64'd13);
      repeat (4) step();
      check("t3_fault_frozen", 64'(fault_cnt), 64'd13);
      check("t3_no_issue_sink", 64'(n_issued), 64'd9);
      bist_done = 1'b1;
      step();
      bist_done = 1'b0;
      req_valid = '0;
      check("t3_done_unrep", {done, unrepairable, pivot_cnt}, {1'b1, 1'b1, 4'd8});
      start = 1'b1;
      #1;
      step();
      start = 1'b0;
      check("t3_restart_clears", {done, unrepairable, pivot_cnt, nonpivot_cnt, fault_cnt}, 64'd0);

      // Non-pivot overflow on the 17th response.
      do_reset();
      begin_session();
      rsp_pivot = 1'b0;
      req_valid = 4'b0001;
      for (int i = 0; i < 100 && !cam_early_term; i++) step();
      check("t4_term_pulse", {63'd0, cam_early_term}, 64'd1);
      check("t4_issued", 64'(n_issued), 64'd17);
      check("t4_counts", {nonpivot_cnt, pivot_cnt, fault_cnt}, {5'd16, 4'd0, 16'd21});
      step();
      check("t4_unrep", {63'd0, unrepairable}, 64'd1);
      req_valid = '0;

      // bist_done with three faults queued.
      do_reset();
      begin_session();
      req_valid = 4'b1111;
      repeat (4) step();
      bist_done = 1'b1;
      step();
      #1;
      check("t5_drain_no_grant", 64'(req_ready), 64'd0);
      check("t5_issued_before", 64'(n_issued), 64'd2);
      wait_done("t5_done", 40);
      bist_done = 1'b0;
      req_valid = '0;
      check("t5_issued_total", 64'(n_issued), 64'd5);
      check("t5_counts", {fault_cnt, nonpivot_cnt}, {16'd5, 5'd5});

      // Same fault reported twice.
      do_reset();
      set_bank(2, 10'd7, 10'd9, 8'hA5);
      begin_session();
      req_valid = 4'b0100;
      #1 check("t6_grant_a", 64'(req_ready), 64'h4);
      step();
      req_valid = '0;
      step();
      req_valid = 4'b0100;
      #1 check("t6_grant_b", 64'(req_ready), 64'h4);
      step();
      req_valid = '0;
      bist_done = 1'b1;
      wait_done("t6_done", 20);
      bist_done = 1'b0;
      check("t6_issues", 64'(n_issued), 64'(DupIssues));
      check("t6_counts", {fault_cnt, nonpivot_cnt}, {16'd2, 5'(DupIssues)});

      // Asynchronous reset mid-COLLECT.
      do_reset();
      begin_session();
      req_valid = 4'b1111;
      step();
      step();
      #2 rst = 1'b0;
      #1;
      check("t7_async_reset", {req_ready, cam_valid, cam_row_addr, cam_col_addr, cam_bank_addr,
            cam_col_flag, cam_early_term, busy, done, unrepairable, pivot_cnt, nonpivot_cnt,
            fault_cnt}, 64'd0);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
